// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter. A word loaded while idle is presented one
// bit per en tick, starting the cycle after capture. All outputs come from
// flops that are fed by next-state logic, so no input reaches an output
// combinationally.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             load,
  input  logic [WIDTH-1:0] P,
  input  logic             en,
  output logic             ready,
  output logic             D,
  output logic             D_valid,
  output logic             first,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             done_n;

  // Bit sitting at the output end of the shift register.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Next-state: capture on load in IDLE, consume one bit per en in SHIFT.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sr_n    = P;
          cnt_n   = FULL;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          sr_n = MSB_FIRST ? (sr << 1) : (sr >> 1);
          // Counter is never zero in SHIFT; the guard keeps it from wrapping.
          if (cnt != '0) cnt_n = cnt - ONE;
          if (cnt <= ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
    endcase
  end

  // Datapath and state registers.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  end

  // Output registers, derived from next-state values so D leads with the
  // first bit right after the capturing edge.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      ready   <= 1'b1;
      D       <= 1'b0;
      D_valid <= 1'b0;
      first   <= 1'b0;
      done    <= 1'b0;
    end else begin
      ready   <= (state_n == IDLE);
      D_valid <= (state_n == SHIFT);
      D       <= (state_n == SHIFT) & out_bit(sr_n);
      first   <= (state_n == SHIFT) && (cnt_n == FULL);
      done    <= done_n;
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width, legal range 1..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port r  input  1  reset; asynchronous, active-high.
REQ-005 Port load  input  1  load request; accepted only when ready=1.
REQ-006 Port P  input  WIDTH  parallel word; sampled on the accepting edge.
REQ-007 Port en  input  1  shift-enable tick; advances one bit per cycle when high.
REQ-008 Port ready  output  1  block idle; able to accept a word.
REQ-009 Port D  output  1  serial data bit.
REQ-010 Port D_valid  output  1  D carries a valid bit of the current word.
REQ-011 Port first  output  1  D carries the first bit of a word.
REQ-012 Port done  output  1  one-cycle pulse after the last bit of a word is consumed.
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 In IDLE: ready=1, D_valid=0, D=0, first=0.
REQ-016 In SHIFT: ready=0, D_valid=1.
REQ-017 IDLE with load=1 at an edge SHALL capture P into the shift register, set the bit counter to WIDTH, and enter SHIFT.
REQ-018 D SHALL present the first bit in the cycle immediately after the accepting edge, giving zero-cycle latency from capture to D_valid.
REQ-019 first SHALL be 1 only while the counter equals WIDTH in SHIFT.
REQ-020 In SHIFT, D SHALL hold its value while en=0, with no limit on stall length.
REQ-021 In SHIFT, en=1 SHALL consume the current bit: the register shifts by one toward the output end and the counter decrements by 1.
REQ-022 When en=1 consumes the final bit (counter=1), the FSM SHALL return to IDLE at that edge and assert done for exactly the following cycle.
REQ-023 done SHALL coincide with ready=1 and D_valid=0.
REQ-024 load while ready=0 SHALL be ignored; P SHALL NOT be captured and the current word SHALL NOT be disturbed.
REQ-025 en in IDLE SHALL be ignored.
REQ-026 load=1 and en=1 in the same IDLE cycle SHALL capture the word only; no bit is consumed at that edge.
REQ-027 Back-to-back words: a load in the done cycle SHALL be accepted, leaving exactly one idle cycle between words.
REQ-028 WIDTH=1: the single bit SHALL be flagged with first=1, and the next en=1 edge SHALL return the FSM to IDLE with done.
REQ-029 The counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL never wrap below 0.
REQ-030 Vacated shift-register positions SHALL fill with 0.

Reset
REQ-031 r=1 SHALL immediately, without waiting for clk, force: state=IDLE, shift register=0, counter=0, ready=1, D=0, D_valid=0, first=0, done=0.
REQ-032 r asserted mid-word SHALL discard the word, with no done pulse generated.
REQ-033 While r=1, load and en SHALL be ignored.
REQ-034 Operation SHALL resume on the first rising edge after r deasserts.

Verification
REQ-035 WIDTH=4, MSB_FIRST=1, P=4'b1011, load one cycle, en=1 continuously -> D=1,0,1,1 on four consecutive cycles; first=1 on the first bit only; done=1 in the fifth cycle.
REQ-036 Same word with MSB_FIRST=0 -> D=1,1,0,1.
REQ-037 P=4'b0110, en toggling 1/0 each cycle -> each bit is held 2 cycles; sequence 0,1,1,0; done follows the fourth en=1 edge.
REQ-038 load pulsed with P=4'b1111 during SHIFT of 4'b1000 -> output stays 1,0,0,0; ready stays 0 until done.
REQ-039 Assert r for 5 ns at 7 ns after the second bit has been output -> D_valid=0 and ready=1 before the next clk edge; no done pulse occurs.
REQ-040 Back-to-back: P=4'b1010 then P=4'b0101, load held high -> second word starts in the done cycle; D=1,0,1,0,-,0,1,0,1.
